// File: rtl/vga_sync.sv
// vga_sync: 640x480@60Hz VGA timing generator with a clk/2 pixel-enable tick
module vga_sync #(
  parameter int HD = 640,
  parameter int HF = 16,
  parameter int HR = 96,
  parameter int HB = 48,
  parameter int VD = 480,
  parameter int VF = 10,
  parameter int VR = 2,
  parameter int VB = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       ENclock,
  output logic [9:0] px_X,
  output logic [9:0] px_Y
);
  localparam logic [9:0] X_LAST = 10'(HD + HF + HR + HB - 1);
  localparam logic [9:0] Y_LAST = 10'(VD + VF + VR + VB - 1);
  localparam logic [9:0] HS_LO  = 10'(HD + HF);
  localparam logic [9:0] HS_HI  = 10'(HD + HF + HR - 1);
  localparam logic [9:0] VS_LO  = 10'(VD + VF);
  localparam logic [9:0] VS_HI  = 10'(VD + VF + VR - 1);
  logic       x_wrap;
  logic [9:0] x_n, y_n;
  // next counter values; out-of-range counts fall back to 0 on the next tick
  always_comb begin
    x_wrap = px_X >= X_LAST;
    x_n    = !ENclock ? px_X : x_wrap ? '0 : px_X + 10'd1;
    y_n    = !ENclock ? px_Y : px_Y > Y_LAST ? '0 : !x_wrap ? px_Y : px_Y == Y_LAST ? '0 : px_Y + 10'd1;
  end
  // tick, counters and syncs registered together so syncs line up with the counters
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ENclock <= 1'b0;
      px_X    <= '0;
      px_Y    <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      ENclock <= !ENclock;
      px_X    <= x_n;
      px_Y    <= y_n;
      hsync   <= !(x_n >= HS_LO && x_n <= HS_HI);
      vsync   <= !(y_n >= VS_LO && y_n <= VS_HI);
    end
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: scoreboard bench for vga_sync at full and reduced timing
module tb_vga_sync;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hs_d, vs_d, en_d, hs_s, vs_s, en_s;
  logic [9:0] x_d, y_d, x_s, y_s;
  always #10 clk = ~clk;
  vga_sync dut (
    .clk(clk), .rst(rst), .hsync(hs_d), .vsync(vs_d), .ENclock(en_d), .px_X(x_d), .px_Y(y_d)
  );
  vga_sync #(.HD(16), .HF(4), .HR(6), .HB(4), .VD(8), .VF(2), .VR(2), .VB(3)) dut_s (
    .clk(clk), .rst(rst), .hsync(hs_s), .vsync(vs_s), .ENclock(en_s), .px_X(x_s), .px_Y(y_s)
  );
  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int failures = 0;
  int ht[2]  = '{800, 30};
  int vt[2]  = '{525, 15};
  int hs0[2] = '{656, 20};
  int hs1[2] = '{751, 25};
  int vs0[2] = '{490, 10};
  int vs1[2] = '{491, 11};
  int mx[2], my[2];
  bit mt;
  int hfall, vfall, hlow;
  logic phs, pvs;
  function automatic exp_t mk(int i);
    exp_t r;
    r.en = mt;
    r.x  = 10'(mx[i]);
    r.y  = 10'(my[i]);
    r.hs = !(mx[i] >= hs0[i] && mx[i] <= hs1[i]);
    r.vs = !(my[i] >= vs0[i] && my[i] <= vs1[i]);
    return r;
  endfunction
  task automatic model_reset();
    mt = 1'b0;
    mx = '{0, 0};
    my = '{0, 0};
  endtask
  task automatic advance();
    if (mt)
      for (int i = 0; i < 2; i++)
        if (mx[i] == ht[i] - 1) begin
          mx[i] = 0;
          my[i] = (my[i] == vt[i] - 1) ? 0 : my[i] + 1;
        end else mx[i] = mx[i] + 1;
    mt = !mt;
  endtask
  task automatic push_all();
    q0.push_back(mk(0));
    q1.push_back(mk(1));
  endtask
  task automatic chk(string tag, logic [9:0] got, logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic compare();
    exp_t e;
    e = q0.pop_front();
    chk("d_en", {9'b0, en_d}, {9'b0, e.en});
    chk("d_x", x_d, e.x);
    chk("d_y", y_d, e.y);
    chk("d_hs", {9'b0, hs_d}, {9'b0, e.hs});
    chk("d_vs", {9'b0, vs_d}, {9'b0, e.vs});
    e = q1.pop_front();
    chk("s_en", {9'b0, en_s}, {9'b0, e.en});
    chk("s_x", x_s, e.x);
    chk("s_y", y_s, e.y);
    chk("s_hs", {9'b0, hs_s}, {9'b0, e.hs});
    chk("s_vs", {9'b0, vs_s}, {9'b0, e.vs});
  endtask
  task automatic step();
    advance();
    push_all();
    @(posedge clk);
    #1;
    compare();
    if (phs && !hs_s) hfall++;
    if (pvs && !vs_s) vfall++;
    if (!hs_d) hlow++;
    phs = hs_s;
    pvs = vs_s;
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    push_all();
    compare();
    @(negedge clk);
    rst = 1'b1;
    hfall = 0;
    vfall = 0;
    hlow = 0;
    phs = hs_s;
    pvs = vs_s;
    repeat (900) step();
    chk("s_hpulses", 10'(hfall), 10'd15);
    chk("s_vpulses", 10'(vfall), 10'd1);
    chk("s_frame_x", x_s, 10'd0);
    chk("s_frame_y", y_s, 10'd0);
    repeat (700) step();
    chk("d_hlow", 10'(hlow), 10'd192);
    chk("d_line_x", x_d, 10'd0);
    chk("d_line_y", y_d, 10'd1);
    repeat (100) step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    push_all();
    compare();
    @(posedge clk);
    #1;
    push_all();
    compare();
    @(negedge clk);
    rst = 1'b1;
    repeat (60) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
